serial_pattern_tx: RTL

//  Serial pattern transmitter: accepts a WIDTH-bit word over a valid/ready handshake
//  and shifts it out MSB-first, one bit per clk, on dout.

---
 rtl/serial_pattern_tx_pkg.sv | 14 +
 rtl/serial_pattern_tx_if.sv | 25 ++
 rtl/serial_pattern_tx_shift_reg.sv | 26 ++
 rtl/serial_pattern_tx.sv | 116 +++++++++++
 4 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter and its benches.
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } tx_state_t;

  localparam logic [4:0] PAT_10101 = 5'b10101;
  localparam logic [4:0] PAT_01011 = 5'b01011;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Load handshake and serial output bundle of the pattern transmitter.
interface serial_pattern_tx_if #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned REP_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [REP_W-1:0] in_reps;
  logic             abort;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data, in_reps, abort,
    input  in_ready, dout, dout_valid, busy, done
  );

  modport slave (
    input  in_valid, in_data, in_reps, abort,
    output in_ready, dout, dout_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx_shift_reg.sv
// Loadable shift-left register presenting its MSB as the serial bit.
module serial_pattern_tx_shift_reg #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);
  logic [WIDTH-1:0] shreg_q;

  // Load has priority over shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = shreg_q[WIDTH-1];
endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: MSB-first frames with repeat count and inter-frame gap.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned REP_W      = 4,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  serial_pattern_tx_if.slave bus
);
  localparam int unsigned BCW = $clog2(WIDTH);
  localparam int unsigned GW  = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  tx_state_t        state_q;
  logic [WIDTH-1:0] pat_q;
  logic [REP_W-1:0] reps_left_q;
  logic [BCW-1:0]   bit_cnt_q;
  logic [GW-1:0]    gap_cnt_q;

  logic             load_c;
  logic             shift_c;
  logic [WIDTH-1:0] src_c;
  logic             msb;
  logic             last_bit_c;
  logic             more_reps_c;

  assign last_bit_c  = (bit_cnt_q == '0);
  assign more_reps_c = (reps_left_q > REP_W'(1));

  // Shift-register control: load on accept or on frame repeat, otherwise shift while sending.
  always_comb begin
    load_c  = 1'b0;
    shift_c = 1'b0;
    src_c   = pat_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && !bus.abort) begin
          load_c = 1'b1;
          src_c  = bus.in_data;
        end
      end
      SHIFT: begin
        if (!bus.abort) begin
          if (last_bit_c && more_reps_c) load_c  = 1'b1;
          else                           shift_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

  serial_pattern_tx_shift_reg #(.WIDTH(WIDTH)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load_c),
    .shift_i (shift_c),
    .data_i  (src_c),
    .msb_o   (msb)
  );

  // Transfer FSM with bit, repeat and gap counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pat_q       <= '0;
      reps_left_q <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && !bus.abort) begin
            pat_q       <= bus.in_data;
            reps_left_q <= (bus.in_reps == '0) ? REP_W'(1) : bus.in_reps;
            bit_cnt_q   <= BCW'(WIDTH - 1);
            state_q     <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.abort) begin
            state_q <= IDLE;
          end else if (last_bit_c) begin
            if (more_reps_c) begin
              reps_left_q <= reps_left_q - REP_W'(1);
              bit_cnt_q   <= BCW'(WIDTH - 1);
              if (GAP_CYCLES > 0) begin
                gap_cnt_q <= GW'(GAP_CYCLES - 1);
                state_q   <= GAP;
              end
            end else begin
              state_q <= DONE;
            end
          end else begin
            bit_cnt_q <= bit_cnt_q - BCW'(1);
          end
        end
        GAP: begin
          if (bus.abort)               state_q   <= IDLE;
          else if (gap_cnt_q == '0)    state_q   <= SHIFT;
          else                         gap_cnt_q <= gap_cnt_q - GW'(1);
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Moore output decodes of registered state.
  assign bus.dout_valid = (state_q == SHIFT);
  assign bus.dout       = (state_q == SHIFT) && msb;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.in_ready   = (state_q == IDLE) && !rst;
endmodule
